// File: rtl/micro_sequencer_if.sv
// Bundle between the microprogram sequencer and its micro-memory / control side.
// The sequencer side uses the master modport; the micro-memory/decode side uses slave.
interface micro_sequencer_if #(
  parameter int ADDR_W      = 7,
  parameter int STACK_DEPTH = 4,
  parameter int OP_W        = 4,
  parameter int CD_W        = 2
);
  localparam int LVL_W = $clog2(STACK_DEPTH + 1);

  logic [CD_W-1:0]        uinst_cd;
  logic                   uinst_inv;
  logic [1:0]             uinst_br;
  logic [ADDR_W-1:0]      uinst_addr;
  logic [(1<<CD_W)-1:0]   cond_vec;
  logic [OP_W-1:0]        opcode;
  logic                   halt_req;
  logic                   resume;
  logic                   stall;

  logic [ADDR_W-1:0]      car;
  logic                   exec_en;
  logic                   halted;
  logic                   fault;
  logic [1:0]             fault_code;
  logic [LVL_W-1:0]       stack_level;

  modport master (
    input  uinst_cd, uinst_inv, uinst_br, uinst_addr, cond_vec, opcode,
           halt_req, resume, stall,
    output car, exec_en, halted, fault, fault_code, stack_level
  );

  modport slave (
    output uinst_cd, uinst_inv, uinst_br, uinst_addr, cond_vec, opcode,
           halt_req, resume, stall,
    input  car, exec_en, halted, fault, fault_code, stack_level
  );
endinterface

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: CAR, return-address stack and a fetch/execute FSM
// matched to a 1-cycle synchronous micro-memory, with stall, halt and stack faults.
module micro_sequencer #(
  parameter int ADDR_W      = 7,
  parameter int STACK_DEPTH = 4,
  parameter int OP_W        = 4,
  parameter int MAP_SHIFT   = 2,
  parameter int CD_W        = 2,
  parameter int RESET_ADDR  = 0
) (
  input  logic clk,
  input  logic reset,
  micro_sequencer_if.master bus
);
  localparam int LVL_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int MAP_W = OP_W + MAP_SHIFT;

  localparam logic [1:0] S_FETCH  = 2'd0;
  localparam logic [1:0] S_EXEC   = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;
  localparam logic [1:0] S_FAULT  = 2'd3;

  localparam logic [1:0] BR_JMP  = 2'b00;
  localparam logic [1:0] BR_CALL = 2'b01;
  localparam logic [1:0] BR_RET  = 2'b10;

  localparam logic [1:0] FC_NONE = 2'b00;
  localparam logic [1:0] FC_OVF  = 2'b01;
  localparam logic [1:0] FC_UNF  = 2'b10;

  logic [1:0]        state;
  logic [ADDR_W-1:0] car_q;
  logic [LVL_W-1:0]  level_q;
  logic [1:0]        fcode_q;
  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

  logic              cond_true;
  logic              stack_full;
  logic              stack_empty;
  logic              do_push;
  logic [ADDR_W-1:0] car_inc;
  logic [ADDR_W-1:0] map_addr;
  logic [ADDR_W-1:0] top_entry;
  logic [MAP_W-1:0]  map_full;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  pop_idx;

  // cd==0 selects "always"; cond_vec[0] is never consulted.
  assign cond_true   = ((bus.uinst_cd == '0) ? 1'b1 : bus.cond_vec[bus.uinst_cd]) ^ bus.uinst_inv;
  assign car_inc     = car_q + ADDR_W'(1);
  assign map_full    = MAP_W'(bus.opcode) << MAP_SHIFT;
  assign map_addr    = ADDR_W'(map_full);
  assign stack_full  = (level_q == LVL_W'(STACK_DEPTH));
  assign stack_empty = (level_q == '0);
  assign push_idx    = IDX_W'(level_q);
  assign pop_idx     = IDX_W'(level_q - LVL_W'(1));
  assign top_entry   = stack_mem[pop_idx];
  assign do_push     = (state == S_EXEC) && !bus.stall && !bus.halt_req && cond_true &&
                       (bus.uinst_br == BR_CALL) && !stack_full;

  // NOTE: storage arrays carry no reset; stack_level alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) stack_mem[push_idx] <= car_inc;
  end

  // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      car_q   <= ADDR_W'(RESET_ADDR);
      level_q <= '0;
      fcode_q <= FC_NONE;
    end else begin
      case (state)
        S_FETCH: state <= S_EXEC;

        S_EXEC: begin
          if (!bus.stall) begin
            if (bus.halt_req) begin
              state <= S_HALTED;
            end else if (!cond_true) begin
              car_q <= car_inc;
              state <= S_FETCH;
            end else begin
              case (bus.uinst_br)
                BR_JMP: begin
                  car_q <= bus.uinst_addr;
                  state <= S_FETCH;
                end
                BR_CALL: begin
                  if (stack_full) begin
                    state   <= S_FAULT;
                    fcode_q <= FC_OVF;
                  end else begin
                    car_q   <= bus.uinst_addr;
                    level_q <= level_q + LVL_W'(1);
                    state   <= S_FETCH;
                  end
                end
                BR_RET: begin
                  if (stack_empty) begin
                    state   <= S_FAULT;
                    fcode_q <= FC_UNF;
                  end else begin
                    car_q   <= top_entry;
                    level_q <= level_q - LVL_W'(1);
                    state   <= S_FETCH;
                  end
                end
                default: begin
                  car_q <= map_addr;
                  state <= S_FETCH;
                end
              endcase
            end
          end
        end

        S_HALTED: begin
          if (bus.resume) begin
            car_q <= car_inc;
            state <= S_FETCH;
          end
        end

        default: ; // FAULT is left only through reset
      endcase
    end
  end

  assign bus.car         = car_q;
  assign bus.exec_en     = (state == S_EXEC);
  assign bus.halted      = (state == S_HALTED);
  assign bus.fault       = (state == S_FAULT);
  assign bus.fault_code  = fcode_q;
  assign bus.stack_level = level_q;
endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench for micro_sequencer: directed scenarios plus random stimulus,
// expectations come from a transaction-level model of the sequencing rules.
module tb_micro_sequencer;
  localparam int ADDR_W      = 7;
  localparam int STACK_DEPTH = 4;
  localparam int OP_W        = 4;
  localparam int MAP_SHIFT   = 2;
  localparam int CD_W        = 2;
  localparam int CAR_MOD     = 1 << ADDR_W;

  logic clk;
  logic reset;

  micro_sequencer_if #(.ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH), .OP_W(OP_W), .CD_W(CD_W)) bus ();

  micro_sequencer #(
    .ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH), .OP_W(OP_W),
    .MAP_SHIFT(MAP_SHIFT), .CD_W(CD_W), .RESET_ADDR(0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.master)
  );

  typedef struct packed {
    logic       r;
    logic [1:0] br;
    logic [1:0] cd;
    logic       inv;
    logic [6:0] addr;
    logic [3:0] cv;
    logic [3:0] op;
    logic       hr;
    logic       res;
    logic       st;
  } stim_t;

  typedef struct {
    int car;
    bit exec_en;
    bit halted;
    bit fault;
    int fcode;
    int level;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state: where the program counter is, what is on the return stack,
  // and whether the machine is waiting for memory, executing, halted or dead.
  int   m_car;
  int   m_stack[$];
  bit   m_exec;
  bit   m_halted;
  bit   m_fault;
  int   m_fcode;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_step(stim_t s);
    bit c;
    if (s.r) begin
      m_car = 0; m_stack.delete(); m_exec = 0; m_halted = 0; m_fault = 0; m_fcode = 0;
    end else if (m_fault) begin
      // dead until reset
    end else if (m_halted) begin
      if (s.res) begin
        m_car = (m_car + 1) % CAR_MOD;
        m_halted = 0;
      end
    end else if (!m_exec) begin
      m_exec = 1;
    end else if (s.st) begin
      // frozen
    end else if (s.hr) begin
      m_halted = 1;
      m_exec = 0;
    end else begin
      c = ((s.cd == 0) ? 1'b1 : s.cv[s.cd]) ^ s.inv;
      m_exec = 0;
      if (!c) m_car = (m_car + 1) % CAR_MOD;
      else begin
        case (s.br)
          2'd0: m_car = int'(s.addr);
          2'd1: begin
            if (m_stack.size() == STACK_DEPTH) begin m_fault = 1; m_fcode = 1; end
            else begin m_stack.push_back((m_car + 1) % CAR_MOD); m_car = int'(s.addr); end
          end
          2'd2: begin
            if (m_stack.size() == 0) begin m_fault = 1; m_fcode = 2; end
            else m_car = m_stack.pop_back();
          end
          default: m_car = (int'(s.op) * (1 << MAP_SHIFT)) % CAR_MOD;
        endcase
      end
    end
  endfunction

  task automatic step(stim_t s);
    exp_t e;
    reset          = s.r;
    bus.uinst_br   = s.br;
    bus.uinst_cd   = s.cd;
    bus.uinst_inv  = s.inv;
    bus.uinst_addr = s.addr;
    bus.cond_vec   = s.cv;
    bus.opcode     = s.op;
    bus.halt_req   = s.hr;
    bus.resume     = s.res;
    bus.stall      = s.st;
    model_step(s);
    e.car     = m_car;
    e.exec_en = m_exec;
    e.halted  = m_halted;
    e.fault   = m_fault;
    e.fcode   = m_fcode;
    e.level   = m_stack.size();
    sb.push_back(e);
    @(negedge clk);
  endtask

  // Not-taken jump: the sequencer simply counts up.
  function automatic stim_t nop();
    stim_t s = '0;
    s.cd = 2'd1;
    return s;
  endfunction

  function automatic stim_t rst_stim();
    stim_t s = '0;
    s.r = 1'b1;
    return s;
  endfunction

  task automatic run_until(int target);
    int n = 0;
    while (!(m_exec && m_car == target) && n < 400) begin
      step(nop());
      n++;
    end
    if (n >= 400) begin
      n_checks++;
      n_errors++;
      $display("FAIL run_until: car never reached %0d in EXEC", target);
    end
  endtask

  // Monitor: compare every registered output one step after each issued stimulus.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sb_car",     32'(bus.car),         e.car);
        check("sb_exec_en", 32'(bus.exec_en),     32'(e.exec_en));
        check("sb_halted",  32'(bus.halted),      32'(e.halted));
        check("sb_fault",   32'(bus.fault),       32'(e.fault));
        check("sb_fcode",   32'(bus.fault_code),  e.fcode);
        check("sb_level",   32'(bus.stack_level), e.level);
      end
    end
  end

  initial begin
    stim_t s;

    step(rst_stim());
    step(rst_stim());
    check("rst_car",    32'(bus.car), 0);
    check("rst_exec",   32'(bus.exec_en), 0);
    check("rst_level",  32'(bus.stack_level), 0);
    check("rst_fault",  32'(bus.fault), 0);
    check("rst_fcode",  32'(bus.fault_code), 0);
    check("rst_halted", 32'(bus.halted), 0);

    // free run to the top of the address space and wrap
    step(nop());
    check("fetch_to_exec", 32'(bus.exec_en), 1);
    run_until(127);
    step(nop());
    check("wrap_car",  32'(bus.car), 0);
    check("wrap_exec", 32'(bus.exec_en), 0);

    // CALL at 5, RET at 0x40
    run_until(5);
    s = '0; s.br = 2'd1; s.addr = 7'h40;
    step(s);
    check("call_car",   32'(bus.car), 32'h40);
    check("call_level", 32'(bus.stack_level), 1);
    step(nop());
    s = '0; s.br = 2'd2;
    step(s);
    check("ret_car",   32'(bus.car), 6);
    check("ret_level", 32'(bus.stack_level), 0);

    // nested CALLs until overflow
    step(rst_stim());
    for (int i = 0; i < 5; i++) begin
      step(nop());
      s = '0; s.br = 2'd1; s.addr = 7'(8 * (i + 1));
      step(s);
      if (i < 4) check("nest_level", 32'(bus.stack_level), i + 1);
    end
    check("ovf_fault", 32'(bus.fault), 1);
    check("ovf_fcode", 32'(bus.fault_code), 1);
    check("ovf_car",   32'(bus.car), 32);
    check("ovf_exec",  32'(bus.exec_en), 0);
    s = nop(); s.res = 1'b1; s.st = 1'b1;
    repeat (3) step(s);
    check("ovf_sticky", 32'(bus.fault), 1);
    check("ovf_held",   32'(bus.car), 32);

    // RET on empty stack
    step(rst_stim());
    step(nop());
    s = '0; s.br = 2'd2;
    step(s);
    check("unf_fault", 32'(bus.fault), 1);
    check("unf_fcode", 32'(bus.fault_code), 2);
    step(rst_stim());
    check("unf_clr_fault", 32'(bus.fault), 0);
    check("unf_clr_car",   32'(bus.car), 0);

    // MAP taken, then MAP with a false Z condition
    step(nop());
    s = '0; s.br = 2'd3; s.op = 4'b1011;
    step(s);
    check("map_car", 32'(bus.car), 32'h2C);
    step(nop());
    s.cd = 2'd3; s.cv = 4'b0111;
    step(s);
    check("map_nt_car", 32'(bus.car), 32'h2D);

    // halt at 9, resume, stall, reset while halted
    step(rst_stim());
    run_until(9);
    s = '0; s.br = 2'd0; s.addr = 7'h33; s.hr = 1'b1;
    step(s);
    check("halt_flag", 32'(bus.halted), 1);
    check("halt_car",  32'(bus.car), 9);
    repeat (3) step(s);
    check("halt_hold", 32'(bus.car), 9);
    check("halt_exec", 32'(bus.exec_en), 0);
    s = '0; s.res = 1'b1;
    step(s);
    check("resume_car",  32'(bus.car), 10);
    check("resume_flag", 32'(bus.halted), 0);
    step(nop());
    s = '0; s.st = 1'b1; s.addr = 7'h70;
    repeat (3) step(s);
    check("stall_car",  32'(bus.car), 10);
    check("stall_exec", 32'(bus.exec_en), 1);
    s.st = 1'b0;
    step(s);
    check("unstall_car", 32'(bus.car), 32'h70);
    step(nop());
    s = nop(); s.hr = 1'b1;
    step(s);
    step(rst_stim());
    check("halt_rst_car",  32'(bus.car), 0);
    check("halt_rst_flag", 32'(bus.halted), 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      s.r    = ($urandom_range(0, 39) == 0);
      s.br   = 2'($urandom);
      s.cd   = 2'($urandom);
      s.inv  = 1'($urandom);
      s.addr = 7'($urandom);
      s.cv   = 4'($urandom);
      s.op   = 4'($urandom);
      s.hr   = ($urandom_range(0, 19) == 0);
      s.res  = ($urandom_range(0, 3) == 0);
      s.st   = ($urandom_range(0, 6) == 0);
      step(s);
    end

    @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expectations left unchecked", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
Parametrised microprogram sequencer for the microprogrammed CPU. It owns the control address register (CAR) and a multi-level subroutine stack that replaces the single SBR. It has an explicit fetch/execute state machine matched to the 1-cycle synchronous micro-memory. It also provides stall, halt/resume and stack-fault handling. Field decode (F1/F2/F3) stays external; this block consumes the CD/BR/ADDR fields and the decoded HLT request.

Parameters:
ADDR_W, 7, width of CAR and of the microinstruction ADDR field
STACK_DEPTH, 4, number of return-address entries (>=1)
OP_W, 4, opcode width used by MAP
MAP_SHIFT, 2, left shift applied to opcode on MAP (microroutine slot size 2^MAP_SHIFT)
CD_W, 2, width of condition-select field
RESET_ADDR, 0, CAR value after reset

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
uinst_cd  in  CD_W  condition select from micro-memory output
uinst_inv  in  1  invert the selected condition
uinst_br  in  2  branch type: 00 JMP, 01 CALL, 10 RET, 11 MAP
uinst_addr  in  ADDR_W  branch target field
cond_vec  in  2^CD_W  condition inputs (I, S, Z, ...); bit 0 is ignored, since cd=0 means "always"
opcode  in  OP_W  instruction opcode for MAP
halt_req  in  1  decoded HLT for the current microinstruction
resume  in  1  leave HALTED
stall  in  1  freeze sequencer in EXEC
car  out  ADDR_W  address to micro-memory
exec_en  out  1  microinstruction fields valid; datapath enables must be gated by this
halted  out  1  in HALTED
fault  out  1  sticky stack fault
fault_code  out  2  01 overflow, 10 underflow, 00 none
stack_level  out  clog2(STACK_DEPTH+1)  entries currently on stack

Behaviour:
- Reset (sync, priority over everything):
  - car=RESET_ADDR, stack_level=0, state=FETCH.
  - exec_en=0, halted=0, fault=0, fault_code=00.
  - Stack contents are don't-care.
- States: FETCH, EXEC, HALTED, FAULT. All outputs are registered or decoded from state; there are no combinational paths from inputs to car.
- FETCH: car is presented, exec_en=0. Next state is always EXEC, because the memory data is valid one cycle later.
- EXEC: exec_en=1. A microinstruction therefore takes 2 cycles. In EXEC, evaluation is in priority order:
  1. stall=1: hold all state, remain in EXEC, exec_en stays 1.
  2. halt_req=1: go to HALTED, car unchanged, branch field discarded, no stack change.
  3. Otherwise evaluate the condition: c = (cd==0 ? 1 : cond_vec[cd]) XOR uinst_inv.
- EXEC, c=1, by branch type:
  - JMP: car<=uinst_addr.
  - CALL: if stack_level==STACK_DEPTH, go to FAULT with fault_code=01, car and stack unchanged. Else push car+1 (mod 2^ADDR_W), stack_level+1, car<=uinst_addr.
  - RET: if stack_level==0, go to FAULT with fault_code=10. Else car<=top entry, stack_level-1.
  - MAP: car <= zero-extended (opcode << MAP_SHIFT), truncated to ADDR_W.
- EXEC, c=0: car<=car+1, wrapping from 2^ADDR_W-1 to 0. No stack change.
- EXEC, after any non-fault, non-halt, non-stall outcome: next state is FETCH.
- HALTED:
  - halted=1, exec_en=0, car held.
  - resume=1: car<=car+1, halted<=0, go to FETCH.
  - halt_req is ignored in this state.
- FAULT:
  - fault=1, exec_en=0, car held.
  - Left only by reset; resume and stall are ignored.
- Stack is LIFO. A push at level k writes entry k; a pop reads entry k-1.
- Nesting up to STACK_DEPTH is legal.
- stack_level saturates logically via the fault; it never wraps.

Test Plan:
- Reset then free-run with br=JMP, cd=1, inv=0, cond_vec=0 -> car sequence 0,1,2,...; exec_en toggles 0/1; 127 wraps to 0.
- At car=5: CALL addr=0x40, cd=0, then at 0x40 RET cd=0 -> car 0x40, stack_level 1, then car 6, stack_level 0.
- Five nested CALLs with STACK_DEPTH=4 -> first four succeed with levels 1..4; fifth gives fault=1, fault_code=01, car unchanged, exec_en=0 until reset.
- RET with empty stack right after reset -> fault_code=10; a subsequent reset clears fault and car=0.
- MAP with opcode=4'b1011 -> car=7'b0101100; the same with cd=3, Z=0, inv=0 -> car=car+1 instead.
- halt_req together with JMP at car=9 -> halted=1, car stays 9 while stall/resume are low; resume -> car 10, FETCH. Stall held 3 cycles in EXEC -> car and stack frozen. Reset asserted mid-HALTED -> car=0 on the next edge.
